// File: rtl/vga_plot_arbiter_if.sv
// Plot-port bundle shared by the two drawing engines and the arbiter.
// The master side is the pair of requesters; the slave side is the arbiter.
interface vga_plot_arbiter_if;
  logic        req0;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [2:0]  c0;
  logic        gnt0;
  logic        req1;
  logic [7:0]  x1;
  logic [6:0]  y1;
  logic [2:0]  c1;
  logic        gnt1;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [1:0]  owner;
  logic [15:0] clip_cnt;

  modport master (
    output req0, x0, y0, c0, req1, x1, y1, c1,
    input  gnt0, gnt1, vga_x, vga_y, vga_colour, vga_plot, owner, clip_cnt
  );

  modport slave (
    input  req0, x0, y0, c0, req1, x1, y1, c1,
    output gnt0, gnt1, vga_x, vga_y, vga_colour, vga_plot, owner, clip_cnt
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner arbiter for the VGA adapter plot port with burst-limited
// ownership, registered pixel output and off-screen clipping.
module vga_plot_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int X_MAX     = 159,
  parameter int Y_MAX     = 119
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_plot_arbiter_if.slave  bus
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [BW-1:0]  r_burstCnt;
  logic           r_lastOwner;
  logic [7:0]     r_vgaX;
  logic [6:0]     r_vgaY;
  logic [2:0]     r_vgaColour;
  logic           r_vgaPlot;
  logic [15:0]    r_clipCnt;

  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_accept;
  logic           w_burstEnd;
  logic           w_onScreen;
  logic [7:0]     w_selX;
  logic [6:0]     w_selY;
  logic [2:0]     w_selC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Ties from IDLE go to whichever requester did not own the port last.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_nextState = r_lastOwner ? OWN0 : OWN1;
        end else if (bus.req0) begin
          w_nextState = OWN0;
        end else if (bus.req1) begin
          w_nextState = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          w_nextState = bus.req1 ? OWN1 : IDLE;
        end else if (w_burstEnd && bus.req1) begin
          w_nextState = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          w_nextState = bus.req0 ? OWN0 : IDLE;
        end else if (w_burstEnd && bus.req0) begin
          w_nextState = OWN0;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_gnt0     = (r_state == OWN0);
    w_gnt1     = (r_state == OWN1);
    w_accept   = (w_gnt0 && bus.req0) || (w_gnt1 && bus.req1);
    w_burstEnd = (r_burstCnt == BURST_LAST);
    w_selX     = w_gnt1 ? bus.x1 : bus.x0;
    w_selY     = w_gnt1 ? bus.y1 : bus.y0;
    w_selC     = w_gnt1 ? bus.c1 : bus.c0;
    w_onScreen = (int'(w_selX) <= X_MAX) && (int'(w_selY) <= Y_MAX);
  end

  // Burst counter restarts on every ownership change and after a full burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_burstCnt  <= '0;
      r_lastOwner <= 1'b1;
    end else begin
      if (w_nextState != r_state) begin
        r_burstCnt <= '0;
      end else if (w_accept) begin
        r_burstCnt <= w_burstEnd ? '0 : r_burstCnt + BW'(1);
      end
      if (r_state == OWN0 && w_nextState != OWN0) begin
        r_lastOwner <= 1'b0;
      end else if (r_state == OWN1 && w_nextState != OWN1) begin
        r_lastOwner <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vgaX      <= '0;
      r_vgaY      <= '0;
      r_vgaColour <= '0;
      r_vgaPlot   <= 1'b0;
      r_clipCnt   <= '0;
    end else begin
      r_vgaPlot <= 1'b0;
      if (w_accept) begin
        r_vgaX      <= w_selX;
        r_vgaY      <= w_selY;
        r_vgaColour <= w_selC;
        r_vgaPlot   <= w_onScreen;
        if (!w_onScreen && r_clipCnt != 16'hFFFF) begin
          r_clipCnt <= r_clipCnt + 16'd1;
        end
      end
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.owner      = r_state;
  assign bus.vga_x      = r_vgaX;
  assign bus.vga_y      = r_vgaY;
  assign bus.vga_colour = r_vgaColour;
  assign bus.vga_plot   = r_vgaPlot;
  assign bus.clip_cnt   = r_clipCnt;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: queue-fed requesters, a cycle-level reference
// model of ownership/burst/clipping rules, and directed literal checks.
module tb_vga_plot_arbiter;

  localparam int MB = 4;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk;
  logic rst_n;
  vga_plot_arbiter_if bus();

  vga_plot_arbiter #(.MAX_BURST(MB), .X_MAX(159), .Y_MAX(119)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  pix_t q0[$];
  pix_t q1[$];
  logic randomHold;
  int   passCount;
  int   checkCount;
  int   plotCount;
  int   lastX;
  int   lastY;
  logic gnt1Seen;

  int   mOwner;
  int   mLast;
  int   mBurst;
  int   mX;
  int   mY;
  int   mC;
  int   mPlot;
  int   mClip;
  logic mMine;
  logic mOther;
  int   px;
  int   py;
  int   pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input int which, input int x, input int y, input int c);
    pix_t p;
    p.x = 8'(x);
    p.y = 7'(y);
    p.c = 3'(c);
    if (which == 0) q0.push_back(p);
    else            q1.push_back(p);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    randomHold = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    plotCount = 0;
    gnt1Seen = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.req0 || bus.req1) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", 32'(n < maxCycles), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Requesters: a pixel leaves its queue only after it was seen accepted.
  initial begin
    logic pend0;
    logic pend1;
    logic en0;
    logic en1;
    bus.req0 = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.c0 = '0;
    bus.req1 = 1'b0; bus.x1 = '0; bus.y1 = '0; bus.c1 = '0;
    forever begin
      @(negedge clk);
      pend0 = bus.req0 && bus.gnt0 && rst_n;
      pend1 = bus.req1 && bus.gnt1 && rst_n;
      @(posedge clk);
      #1;
      if (pend0 && q0.size() != 0) void'(q0.pop_front());
      if (pend1 && q1.size() != 0) void'(q1.pop_front());
      en0 = randomHold ? ($urandom_range(0, 3) != 0) : 1'b1;
      en1 = randomHold ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.req0 = (q0.size() != 0) && en0;
      bus.req1 = (q1.size() != 0) && en1;
      if (q0.size() != 0) begin bus.x0 = q0[0].x; bus.y0 = q0[0].y; bus.c0 = q0[0].c; end
      if (q1.size() != 0) begin bus.x1 = q1[0].x; bus.y1 = q1[0].y; bus.c1 = q1[0].c; end
    end
  end

  // Reference model: mOwner 0 none / 1 req0 / 2 req1, mLast is the index that owned last.
  always @(posedge clk) begin
    if (!rst_n) begin
      mOwner = 0; mLast = 1; mBurst = 0;
      mX = 0; mY = 0; mC = 0; mPlot = 0; mClip = 0;
    end else begin
      mPlot = 0;
      if (mOwner == 0) begin
        if (bus.req0 && bus.req1) mOwner = (mLast == 1) ? 1 : 2;
        else if (bus.req0)        mOwner = 1;
        else if (bus.req1)        mOwner = 2;
        mBurst = 0;
      end else begin
        mMine  = (mOwner == 1) ? bus.req0 : bus.req1;
        mOther = (mOwner == 1) ? bus.req1 : bus.req0;
        if (!mMine) begin
          mLast  = mOwner - 1;
          mOwner = mOther ? 3 - mOwner : 0;
          mBurst = 0;
        end else begin
          px = (mOwner == 1) ? int'(bus.x0) : int'(bus.x1);
          py = (mOwner == 1) ? int'(bus.y0) : int'(bus.y1);
          pc = (mOwner == 1) ? int'(bus.c0) : int'(bus.c1);
          mX = px; mY = py; mC = pc;
          if (px <= 159 && py <= 119) mPlot = 1;
          else if (mClip < 65535)     mClip = mClip + 1;
          mBurst = mBurst + 1;
          if (mBurst == MB) begin
            mBurst = 0;
            if (mOther) begin
              mLast  = mOwner - 1;
              mOwner = 3 - mOwner;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("gnt0", 32'(bus.gnt0), 32'(mOwner == 1));
    checkOutput("gnt1", 32'(bus.gnt1), 32'(mOwner == 2));
    checkOutput("owner", 32'(bus.owner), 32'(mOwner));
    checkOutput("vga_plot", 32'(bus.vga_plot), 32'(mPlot));
    checkOutput("vga_x", 32'(bus.vga_x), 32'(mX));
    checkOutput("vga_y", 32'(bus.vga_y), 32'(mY));
    checkOutput("vga_colour", 32'(bus.vga_colour), 32'(mC));
    checkOutput("clip_cnt", 32'(bus.clip_cnt), 32'(mClip));
    checkOutput("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
    if (bus.vga_plot === 1'b1) begin
      plotCount++;
      lastX = int'(bus.vga_x);
      lastY = int'(bus.vga_y);
    end
    if (bus.gnt1 === 1'b1) gnt1Seen = 1'b1;
  end

  initial begin
    int n;
    passCount = 0; checkCount = 0; plotCount = 0;
    lastX = 0; lastY = 0; gnt1Seen = 1'b0; randomHold = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_owner", 32'(bus.owner), 32'd0);
    checkOutput("reset_clip", 32'(bus.clip_cnt), 32'd0);
    rst_n = 1'b1;

    $display("[TB] tie after reset goes to req0");
    applyReset();
    applyStimulus(0, 10, 20, 5);
    applyStimulus(1, 30, 40, 6);
    @(negedge clk);
    checkOutput("tie_gnt0_early", 32'(bus.gnt0), 32'd0);
    @(negedge clk);
    checkOutput("tie_gnt0", 32'(bus.gnt0), 32'd1);
    checkOutput("tie_gnt1", 32'(bus.gnt1), 32'd0);
    checkOutput("tie_owner", 32'(bus.owner), 32'd1);
    @(negedge clk);
    checkOutput("tie_plot", 32'(bus.vga_plot), 32'd1);
    checkOutput("tie_x", 32'(bus.vga_x), 32'd10);
    checkOutput("tie_y", 32'(bus.vga_y), 32'd20);
    waitDrain(50);

    $display("[TB] alternating bursts of %0d", MB);
    applyReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, i, i, 1);
      applyStimulus(1, i, i, 2);
    end
    n = 0;
    while (bus.vga_plot !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("burst_first_plot", 32'(n < 10), 32'd1);
    for (int i = 0; i < 32; i++) begin
      checkOutput("burst_no_gap", 32'(bus.vga_plot), 32'd1);
      checkOutput("burst_source", 32'(bus.vga_colour), ((i / MB) % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    waitDrain(200);

    $display("[TB] clipping from req1");
    applyReset();
    applyStimulus(1, 160, 5, 3);
    applyStimulus(1, 3, 120, 4);
    applyStimulus(1, 159, 119, 7);
    waitDrain(50);
    checkOutput("clip_plots", 32'(plotCount), 32'd1);
    checkOutput("clip_last_x", 32'(lastX), 32'd159);
    checkOutput("clip_last_y", 32'(lastY), 32'd119);
    checkOutput("clip_count", 32'(bus.clip_cnt), 32'd2);

    $display("[TB] reset during req1 burst");
    applyReset();
    for (int i = 0; i < 20; i++) applyStimulus(1, (i % 3 == 0) ? 200 : i, i, 5);
    n = 0;
    while (bus.gnt1 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_gnt1_seen", 32'(n < 10), 32'd1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_gnt0", 32'(bus.gnt0), 32'd0);
    checkOutput("mid_rst_gnt1", 32'(bus.gnt1), 32'd0);
    checkOutput("mid_rst_plot", 32'(bus.vga_plot), 32'd0);
    checkOutput("mid_rst_clip", 32'(bus.clip_cnt), 32'd0);
    checkOutput("mid_rst_owner", 32'(bus.owner), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_regrant", 32'(bus.gnt1), 32'd1);
    waitDrain(100);

    $display("[TB] randomized traffic");
    applyReset();
    randomHold = 1'b1;
    for (int i = 0; i < 400; i++) begin
      applyStimulus(0, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
      applyStimulus(1, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
    end
    waitDrain(5000);
    randomHold = 1'b0;

    $display("[TB] full raster from req0");
    applyReset();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) applyStimulus(0, x, y, x + y);
    waitDrain(20000);
    checkOutput("raster_plots", 32'(plotCount), 32'd19200);
    checkOutput("raster_gnt1_idle", 32'(gnt1Seen), 32'd0);
    checkOutput("raster_clip", 32'(bus.clip_cnt), 32'd0);
    checkOutput("raster_last_x", 32'(lastX), 32'd159);
    checkOutput("raster_last_y", 32'(lastY), 32'd119);

    $display("[TB] clip counter saturation");
    applyReset();
    for (int i = 0; i < 32770; i++) begin
      applyStimulus(0, 160 + (i % 96), i % 128, 1);
      applyStimulus(1, i % 160, 120 + (i % 8), 2);
    end
    waitDrain(70000);
    checkOutput("sat_clip", 32'(bus.clip_cnt), 32'h0000FFFF);
    checkOutput("sat_plots", 32'(plotCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
